// File: rtl/fetch_pkg.sv
`default_nettype none
//============================================================================
// Module      : fetch_pkg
// Description : Shared constants for the fetch stage: RISC-V base opcodes
//               used by immediate generation, the bubble (NOP) word and the
//               fetch FSM state encoding.
// Revision    : 1.0 - initial release
//============================================================================
package fetch_pkg;

    // Base opcodes that carry an immediate
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    // addi x0,x0,0 -- what decode sees whenever there is no real instruction
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Fetch FSM: FETCH issues requests, FLUSH is the one dead cycle after a
    // redirect so the memory can retarget to the new PC.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 1'b0;
    localparam fetch_state_t ST_FLUSH = 1'b1;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
//============================================================================
// Module      : fetch_if
// Description : Instruction-memory request/valid handshake between the fetch
//               stage (master) and instruction memory (slave).
//               imem_req   - fetch request
//               imem_addr  - fetch byte address
//               imem_rdata - returned instruction word
//               imem_valid - imem_rdata valid this cycle
// Revision    : 1.0 - initial release
//============================================================================
interface fetch_if #(
    parameter int PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_stage_imm_gen.sv
`default_nettype none
//============================================================================
// Module      : imm_gen
// Description : Combinational immediate generator. Selects the immediate
//               format from the opcode, sign-extends to 32 bits and returns
//               the low WIDTH bits.
//               i_instr - 32-bit instruction word
//               o_imm   - truncated, sign-extended immediate
// Revision    : 1.0 - initial release
//============================================================================
module imm_gen
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [31:0]      i_instr,
    output logic      [WIDTH-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = 32'd0;
        case (i_instr[6:0])
            OP_IMM, LOAD, JALR:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            STORE:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            BRANCH:
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            LUI, AUIPC:
                w_imm32 = {i_instr[31:12], 12'd0};
            JAL:
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end

    assign o_imm = w_imm32[WIDTH-1:0];

    // Upper bits are dropped by design when WIDTH < 32
    logic w_unused_imm;
    assign w_unused_imm = &{1'b0, w_imm32};

endmodule : imm_gen
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
//============================================================================
// Module      : fetch_stage
// Description : Front-end fetch stage. Holds the PC, fetches instructions
//               over the imem handshake, and presents decoded fields to the
//               decode stage. The immediate is emitted one cycle ahead of the
//               fields because decode registers it one extra stage.
//   clk, rst         - clock, synchronous active-high reset
//   i_stall          - freeze request from downstream
//   i_redirect       - taken branch/jump, load PC from i_redirect_pc
//   i_redirect_pc    - redirect target (bits [1:0] ignored)
//   imem             - instruction memory handshake (master side)
//   o_r_reg1/o_r_reg2/o_wr_reg, o_func3, o_func7, o_opcode - raw fields
//   o_immediate_data - immediate of the next instruction
//   o_pc_out         - address of instruction on the field outputs
//   o_valid_out      - fields carry a real instruction
// Revision    : 1.0 - initial release
//============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_stall,
    input  wire logic                i_redirect,
    input  wire logic [PC_WIDTH-1:0] i_redirect_pc,
    fetch_if.master                  imem,
    output logic      [4:0]          o_r_reg1,
    output logic      [4:0]          o_r_reg2,
    output logic      [4:0]          o_wr_reg,
    output logic      [2:0]          o_func3,
    output logic      [6:0]          o_func7,
    output logic      [6:0]          o_opcode,
    output logic      [WIDTH-1:0]    o_immediate_data,
    output logic      [PC_WIDTH-1:0] o_pc_out,
    output logic                     o_valid_out
);

    localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

    fetch_state_t        r_state;
    logic [PC_WIDTH-1:0] r_pc;

    // Hold register: the word accepted last cycle, waiting to drive fields
    logic [31:0]         r_hold_word;
    logic [PC_WIDTH-1:0] r_hold_pc;
    logic                r_hold_valid;

    logic [31:0]         r_field_word;
    logic [PC_WIDTH-1:0] r_pc_out;
    logic                r_valid_out;
    logic [WIDTH-1:0]    r_imm;

    logic                w_req;
    logic                w_accept;
    logic [WIDTH-1:0]    w_imm_next;
    logic [PC_WIDTH-1:0] w_redirect_pc;

    assign w_req         = (r_state == ST_FETCH) && !i_stall && !i_redirect;
    // imem_valid only means something while a request is outstanding
    assign w_accept      = w_req && imem.imem_valid;
    assign w_redirect_pc = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    imm_gen #(
        .WIDTH   (WIDTH)
    ) u_imm_gen (
        .i_instr (imem.imem_rdata),
        .o_imm   (w_imm_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= '0;
            r_hold_word  <= NOP_WORD;
            r_hold_pc    <= '0;
            r_hold_valid <= 1'b0;
            r_field_word <= NOP_WORD;
            r_pc_out     <= '0;
            r_valid_out  <= 1'b0;
            r_imm        <= '0;
        end else if (i_redirect) begin
            // Anything in flight belongs to the wrong path: drop it
            r_state      <= ST_FLUSH;
            r_pc         <= w_redirect_pc;
            r_hold_word  <= NOP_WORD;
            r_hold_valid <= 1'b0;
            r_field_word <= NOP_WORD;
            r_valid_out  <= 1'b0;
            r_imm        <= '0;
        end else if (i_stall) begin
            // Everything frozen, except FLUSH always lasts exactly one cycle
            r_state <= ST_FETCH;
        end else begin
            r_state      <= ST_FETCH;
            r_field_word <= r_hold_word;
            r_pc_out     <= r_hold_pc;
            r_valid_out  <= r_hold_valid;
            if (w_accept) begin
                r_hold_word  <= imem.imem_rdata;
                r_hold_pc    <= r_pc;
                r_hold_valid <= 1'b1;
                r_imm        <= w_imm_next;
                r_pc         <= r_pc + C_PC_STEP;
            end else begin
                r_hold_word  <= NOP_WORD;
                r_hold_valid <= 1'b0;
                r_imm        <= '0;
            end
        end
    end

    // Fields are plain bit slices regardless of instruction format
    assign o_r_reg1         = r_field_word[19:15];
    assign o_r_reg2         = r_field_word[24:20];
    assign o_wr_reg         = r_field_word[11:7];
    assign o_func3          = r_field_word[14:12];
    assign o_func7          = r_field_word[31:25];
    assign o_opcode         = r_field_word[6:0];
    assign o_immediate_data = r_imm;
    assign o_pc_out         = r_pc_out;
    assign o_valid_out      = r_valid_out;

    logic w_unused_redirect_pc;
    assign w_unused_redirect_pc = &{1'b0, i_redirect_pc[1:0]};

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
//============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fetch_stage;

    localparam int WIDTH    = 8;
    localparam int PC_WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [4:0]          r_reg1, r_reg2, wr_reg;
    logic [2:0]          func3;
    logic [6:0]          func7, opcode;
    logic [WIDTH-1:0]    imm;
    logic [PC_WIDTH-1:0] pc_out;
    logic                valid_out;

    int checks   = 0;
    int failures = 0;

    fetch_if #(.PC_WIDTH(PC_WIDTH)) imem ();

    fetch_stage #(
        .WIDTH            (WIDTH),
        .PC_WIDTH         (PC_WIDTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_stall          (stall),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .imem             (imem.master),
        .o_r_reg1         (r_reg1),
        .o_r_reg2         (r_reg2),
        .o_wr_reg         (wr_reg),
        .o_func3          (func3),
        .o_func7          (func7),
        .o_opcode         (opcode),
        .o_immediate_data (imm),
        .o_pc_out         (pc_out),
        .o_valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [7:0] rpc,
                         input logic v, input logic [31:0] w);
        stall               = s;
        redirect            = r;
        redirect_pc         = rpc;
        imem.imem_valid     = v;
        imem.imem_rdata     = w;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'hFFF00113);

        // Reset held two cycles with imem_valid high
        tick();
        tick();
        check_val("rst_opcode", 32'(opcode), 32'h13);
        check_val("rst_imm", 32'(imm), 32'h0);
        check_val("rst_pc_out", 32'(pc_out), 32'h0);
        check_val("rst_valid", 32'(valid_out), 32'h0);
        check_val("rst_addr", 32'(imem.imem_addr), 32'h0);
        rst = 1'b0;

        // Streaming: addi x1,x0,5 @0
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00500093);
        check_val("s0_req", 32'(imem.imem_req), 32'h1);
        tick();
        check_val("s1_imm", 32'(imm), 32'h05);
        check_val("s1_addr", 32'(imem.imem_addr), 32'h04);
        check_val("s1_valid", 32'(valid_out), 32'h0);

        // addi x2,x0,-1 @4
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'hFFF00113);
        tick();
        check_val("s2_wr_reg", 32'(wr_reg), 32'h1);
        check_val("s2_opcode", 32'(opcode), 32'h13);
        check_val("s2_valid", 32'(valid_out), 32'h1);
        check_val("s2_pc_out", 32'(pc_out), 32'h0);
        check_val("s2_imm", 32'(imm), 32'hFF);
        check_val("s2_addr", 32'(imem.imem_addr), 32'h08);

        // lui x0,0x12345 @8
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h12345037);
        tick();
        check_val("s3_wr_reg", 32'(wr_reg), 32'h2);
        check_val("s3_pc_out", 32'(pc_out), 32'h4);
        check_val("s3_imm", 32'(imm), 32'h00);

        // beq x0,x0,-4 @12
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'hFE000EE3);
        tick();
        check_val("s4_opcode", 32'(opcode), 32'h37);
        check_val("s4_pc_out", 32'(pc_out), 32'h8);
        check_val("s4_imm", 32'(imm), 32'hFC);
        check_val("s4_addr", 32'(imem.imem_addr), 32'h10);

        // Stall three cycles with a word offered: nothing may move
        drive(1'b1, 1'b0, 8'h00, 1'b1, 32'h00A00193);
        check_val("st_req", 32'(imem.imem_req), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("st_imm", 32'(imm), 32'hFC);
            check_val("st_pc_out", 32'(pc_out), 32'h8);
            check_val("st_opcode", 32'(opcode), 32'h37);
            check_val("st_addr", 32'(imem.imem_addr), 32'h10);
        end

        // Release: beq reaches fields, addi x3,x0,10 @16 accepted
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00A00193);
        check_val("rel_req", 32'(imem.imem_req), 32'h1);
        tick();
        check_val("rel_pc_out", 32'(pc_out), 32'hC);
        check_val("rel_wr_reg", 32'(wr_reg), 32'd29);
        check_val("rel_func7", 32'(func7), 32'h7F);
        check_val("rel_valid", 32'(valid_out), 32'h1);
        check_val("rel_imm", 32'(imm), 32'h0A);
        check_val("rel_addr", 32'(imem.imem_addr), 32'h14);

        // No data this cycle: bubble into hold, PC stays
        drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        tick();
        check_val("nv_pc_out", 32'(pc_out), 32'h10);
        check_val("nv_wr_reg", 32'(wr_reg), 32'h3);
        check_val("nv_imm", 32'(imm), 32'h0);
        check_val("nv_addr", 32'(imem.imem_addr), 32'h14);

        // addi x4,x0,7 @20 accepted, then killed by a redirect
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00700213);
        tick();
        check_val("b_valid", 32'(valid_out), 32'h0);
        check_val("b_opcode", 32'(opcode), 32'h13);
        check_val("b_imm", 32'(imm), 32'h07);

        // Redirect with simultaneous stall and imem_valid
        drive(1'b1, 1'b1, 8'h42, 1'b1, 32'h00F00393);
        check_val("rd_req", 32'(imem.imem_req), 32'h0);
        tick();
        check_val("rd_valid", 32'(valid_out), 32'h0);
        check_val("rd_imm", 32'(imm), 32'h0);
        check_val("rd_addr", 32'(imem.imem_addr), 32'h40);

        // FLUSH cycle: no request even after stall is dropped
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00F00393);
        check_val("fl_req", 32'(imem.imem_req), 32'h0);
        stall = 1'b1;
        tick();

        // Stall in FLUSH did not extend it
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00100293);
        check_val("ft_req", 32'(imem.imem_req), 32'h1);
        check_val("ft_addr", 32'(imem.imem_addr), 32'h40);
        tick();
        check_val("ft_valid", 32'(valid_out), 32'h0);
        check_val("ft_imm", 32'(imm), 32'h01);
        check_val("ft_addr2", 32'(imem.imem_addr), 32'h44);

        drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        tick();
        check_val("nw_pc_out", 32'(pc_out), 32'h40);
        check_val("nw_wr_reg", 32'(wr_reg), 32'h5);
        check_val("nw_valid", 32'(valid_out), 32'h1);

        // PC wrap from 0xFC
        drive(1'b0, 1'b1, 8'hFC, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        check_val("wr_flush_req", 32'(imem.imem_req), 32'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 32'h00900313);
        check_val("wr_addr", 32'(imem.imem_addr), 32'hFC);
        tick();
        check_val("wr_wrap", 32'(imem.imem_addr), 32'h00);
        check_val("wr_imm", 32'(imm), 32'h09);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        tick();
        check_val("wr_pc_out", 32'(pc_out), 32'hFC);
        check_val("wr_wr_reg", 32'(wr_reg), 32'h6);

        // Reset beats a simultaneous redirect
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h80, 1'b1, 32'h00500093);
        tick();
        check_val("rr_addr", 32'(imem.imem_addr), 32'h0);
        check_val("rr_valid", 32'(valid_out), 32'h0);
        check_val("rr_opcode", 32'(opcode), 32'h13);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
        check_val("rr_req", 32'(imem.imem_req), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
